// File: rtl/branch_predictor_2bit.sv
// branch_predictor_2bit: 2-bit counter direction predictor with a direct-mapped BTB.
// Lookup is combinational on the fetch PC; training, stale-entry cleanup and statistics happen from EX.
module branch_predictor_2bit #(
    parameter int INDEX_W = 6,
    parameter int XLEN    = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc_if,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_ex_valid,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic            i_ex_is_branch,
    input  logic            i_ex_is_jump,
    input  logic            i_ex_taken,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_ctrl_cnt,
    output logic [31:0]     o_mispred_cnt
);
    localparam int N  = 1 << INDEX_W;
    localparam int TW = XLEN - INDEX_W - 2;

    logic [N-1:0]      valid_q, valid_d;
    logic [TW-1:0]     tag_q [N];
    logic [TW-1:0]     tag_d [N];
    logic [XLEN-1:0]   tgt_q [N];
    logic [XLEN-1:0]   tgt_d [N];
    logic [1:0]        ctr_q [N];
    logic [1:0]        ctr_d [N];
    logic [31:0]       ctrl_cnt_q, ctrl_cnt_d, mispred_cnt_q, mispred_cnt_d;
    logic [INDEX_W-1:0] if_idx, ex_idx;
    logic [TW-1:0]     if_tag, ex_tag;
    logic              if_hit, ex_hit, train, stale;

    assign if_idx = i_pc_if[INDEX_W+1:2];
    assign if_tag = i_pc_if[XLEN-1:INDEX_W+2];
    assign ex_idx = i_ex_pc[INDEX_W+1:2];
    assign ex_tag = i_ex_pc[XLEN-1:INDEX_W+2];

    always_comb begin
        if_hit        = valid_q[if_idx] && tag_q[if_idx] == if_tag;
        o_pred_taken  = if_hit && ctr_q[if_idx][1];
        o_pred_target = o_pred_taken ? tgt_q[if_idx] : i_pc_if + XLEN'(4);
    end

    always_comb begin
        ex_hit        = valid_q[ex_idx] && tag_q[ex_idx] == ex_tag;
        train         = i_ex_valid && (i_ex_is_branch || i_ex_is_jump);
        stale         = i_ex_valid && !i_ex_is_branch && !i_ex_is_jump && i_ex_pred_taken;
        o_mispredict  = i_ex_valid && ((i_ex_taken != i_ex_pred_taken) ||
                                       (i_ex_taken && i_ex_target != i_ex_pred_target));
        o_redirect_pc = (i_ex_valid && i_ex_taken) ? i_ex_target : i_ex_pc + XLEN'(4);
        ctrl_cnt_d    = ctrl_cnt_q + 32'(train);
        mispred_cnt_d = mispred_cnt_q + 32'(o_mispredict);
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (train && ex_hit) begin
            ctr_d[ex_idx] = i_ex_is_jump ? 2'b11 :
                            i_ex_taken   ? ((ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01) :
                                           ((ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01);
            if (i_ex_is_jump || i_ex_taken) tgt_d[ex_idx] = i_ex_target;
        end else if (train && i_ex_taken) begin
            valid_d[ex_idx] = 1'b1;
            tag_d[ex_idx]   = ex_tag;
            tgt_d[ex_idx]   = i_ex_target;
            ctr_d[ex_idx]   = i_ex_is_jump ? 2'b11 : 2'b10;
        end
        // Non-control instruction predicted taken: drop the leftover entry
        if (stale && ex_hit) valid_d[ex_idx] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q       <= '0;
            ctrl_cnt_q    <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < N; i++) ctr_q[i] <= 2'b00;
        end else begin
            valid_q       <= valid_d;
            ctrl_cnt_q    <= ctrl_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            ctr_q         <= ctr_d;
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they need no reset
    always_ff @(posedge i_clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    assign o_ctrl_cnt    = ctrl_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor_2bit.sv
// tb_branch_predictor_2bit: directed vector table, reset corner cases and random traffic vs a behavioural model.
module tb_branch_predictor_2bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_if, ex_pc, ex_tgt, ex_ptgt, pred_tgt, redir, ctrl_cnt, misp_cnt;
    logic        ex_v, ex_br, ex_jp, ex_tk, ex_ptk, pred_tk, misp;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    branch_predictor_2bit dut (
        .i_clk(clk), .i_reset(rst), .i_pc_if(pc_if),
        .o_pred_taken(pred_tk), .o_pred_target(pred_tgt),
        .i_ex_valid(ex_v), .i_ex_pc(ex_pc), .i_ex_is_branch(ex_br), .i_ex_is_jump(ex_jp),
        .i_ex_taken(ex_tk), .i_ex_target(ex_tgt), .i_ex_pred_taken(ex_ptk),
        .i_ex_pred_target(ex_ptgt), .o_mispredict(misp), .o_redirect_pc(redir),
        .o_ctrl_cnt(ctrl_cnt), .o_mispred_cnt(misp_cnt)
    );

    typedef struct {
        logic [31:0] pc_if;
        logic        v, br, jp, tk;
        logic [31:0] ex_pc, ex_tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [31:0] pi, logic v, logic br, logic jp, logic tk,
                                logic [31:0] ep, logic [31:0] et, logic pt, logic [31:0] ptg,
                                logic ept, logic [31:0] eptg, logic em, logic [31:0] er);
        vec_t r;
        r.pc_if = pi; r.v = v; r.br = br; r.jp = jp; r.tk = tk; r.ex_pc = ep; r.ex_tgt = et;
        r.ptk = pt; r.ptgt = ptg; r.e_ptk = ept; r.e_ptgt = eptg; r.e_mis = em; r.e_red = er;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        pc_if = x.pc_if; ex_v = x.v; ex_br = x.br; ex_jp = x.jp; ex_tk = x.tk;
        ex_pc = x.ex_pc; ex_tgt = x.ex_tgt; ex_ptk = x.ptk; ex_ptgt = x.ptgt;
    endtask

    // Behavioural model: one record per table slot, counter kept as a 0..3 integer
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    int unsigned m_cc, m_mc;

    function automatic int mi(logic [31:0] pc); return int'((pc >> 2) % 64); endfunction
    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[mi(pc)] && m_tag[mi(pc)] == (pc >> 8);
    endfunction
    function automatic bit m_ptk(logic [31:0] pc); return m_hit(pc) && m_ctr[mi(pc)] >= 2; endfunction
    function automatic logic [31:0] m_ptgt(logic [31:0] pc);
        return m_ptk(pc) ? m_tgt[mi(pc)] : pc + 32'd4;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
        m_cc = 0; m_mc = 0;
    endtask

    initial begin
        logic [31:0] pool [6];
        bit          e_mis, h;
        int          k;
        pool[0] = 32'h0000_0080; pool[1] = 32'h0000_0300; pool[2] = 32'h0000_0340;
        pool[3] = 32'h1234_5678; pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h0000_0104;

        tbl[0]  = mk(32'h100, 0, 0, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h004);
        tbl[1]  = mk(32'h100, 1, 1, 0, 1, 32'h100, 32'h080, 0, 32'h000, 0, 32'h104, 1, 32'h080);
        tbl[2]  = mk(32'h100, 1, 1, 0, 1, 32'h100, 32'h080, 1, 32'h080, 1, 32'h080, 0, 32'h080);
        tbl[3]  = mk(32'h100, 1, 1, 0, 1, 32'h100, 32'h080, 1, 32'h080, 1, 32'h080, 0, 32'h080);
        tbl[4]  = mk(32'h100, 1, 1, 0, 1, 32'h100, 32'h080, 1, 32'h080, 1, 32'h080, 0, 32'h080);
        tbl[5]  = mk(32'h100, 1, 1, 0, 0, 32'h100, 32'h080, 1, 32'h080, 1, 32'h080, 1, 32'h104);
        tbl[6]  = mk(32'h100, 1, 1, 0, 0, 32'h100, 32'h080, 1, 32'h080, 1, 32'h080, 1, 32'h104);
        tbl[7]  = mk(32'h100, 0, 0, 0, 0, 32'h100, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h104);
        tbl[8]  = mk(32'h200, 1, 0, 1, 1, 32'h200, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300);
        tbl[9]  = mk(32'h200, 1, 0, 1, 1, 32'h200, 32'h340, 1, 32'h300, 1, 32'h300, 1, 32'h340);
        tbl[10] = mk(32'h200, 0, 0, 0, 0, 32'h200, 32'h000, 0, 32'h000, 1, 32'h340, 0, 32'h204);
        tbl[11] = mk(32'h100, 1, 0, 0, 0, 32'h200, 32'h000, 1, 32'h340, 0, 32'h104, 1, 32'h204);
        tbl[12] = mk(32'h200, 0, 0, 0, 0, 32'h200, 32'h000, 0, 32'h000, 0, 32'h204, 0, 32'h204);
        tbl[13] = mk(32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h55, 0, 0, 0, 32'h0, 0, 32'h0);

        drive(tbl[0]);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ctrl_cnt", ctrl_cnt, 0);
        chk("reset_misp_cnt", misp_cnt, 0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_pred_taken", i), 32'(pred_tk), 32'(tbl[i].e_ptk));
            chk($sformatf("v%0d_pred_target", i), pred_tgt, tbl[i].e_ptgt);
            chk($sformatf("v%0d_mispredict", i), 32'(misp), 32'(tbl[i].e_mis));
            chk($sformatf("v%0d_redirect", i), redir, tbl[i].e_red);
        end
        chk("tbl_ctrl_cnt", ctrl_cnt, 8);
        chk("tbl_misp_cnt", misp_cnt, 6);

        // Reset asserted mid-cycle while an entry predicts taken
        @(negedge clk);
        drive(mk(32'h100, 1, 1, 0, 1, 32'h100, 32'h080, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        ex_v = 1'b1; ex_ptk = 1'b1; ex_ptgt = 32'h080;
        #1;
        chk("pre_reset_pred_taken", 32'(pred_tk), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_pred_taken", 32'(pred_tk), 0);
        chk("async_reset_pred_target", pred_tgt, 32'h104);
        chk("async_reset_ctrl_cnt", ctrl_cnt, 0);
        chk("async_reset_misp_cnt", misp_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0; ex_v = 1'b0;
        #1;
        chk("post_reset_pred_taken", 32'(pred_tk), 0);
        chk("post_reset_pred_target", pred_tgt, 32'h104);
        chk("post_reset_ctrl_cnt", ctrl_cnt, 0);
        chk("post_reset_misp_cnt", misp_cnt, 0);

        m_clear();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            pc_if = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 15) == 0) pc_if = 32'hFFFF_FFFC;
            ex_pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            k = int'($urandom_range(0, 3));
            ex_v  = $urandom_range(0, 7) != 0;
            ex_br = k == 0 || k == 1;
            ex_jp = k == 2;
            ex_tk = ex_jp ? 1'b1 : ex_br ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!ex_v) ex_tk = 1'($urandom_range(0, 1));
            ex_tgt = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) != 0) begin
                ex_ptk = m_ptk(ex_pc); ex_ptgt = m_ptgt(ex_pc);
            end else begin
                ex_ptk = 1'($urandom_range(0, 1)); ex_ptgt = pool[$urandom_range(0, 5)];
            end
            #1;
            e_mis = ex_v && ((ex_tk != ex_ptk) || (ex_tk && ex_tgt != ex_ptgt));
            chk("rnd_pred_taken", 32'(pred_tk), 32'(m_ptk(pc_if)));
            chk("rnd_pred_target", pred_tgt, m_ptgt(pc_if));
            chk("rnd_mispredict", 32'(misp), 32'(e_mis));
            chk("rnd_redirect", redir, (ex_v && ex_tk) ? ex_tgt : ex_pc + 32'd4);
            chk("rnd_ctrl_cnt", ctrl_cnt, m_cc);
            chk("rnd_misp_cnt", misp_cnt, m_mc);
            k = mi(ex_pc);
            h = m_hit(ex_pc);
            if (ex_v && (ex_br || ex_jp)) begin
                m_cc++;
                if (h) begin
                    if (ex_jp) m_ctr[k] = 3;
                    else m_ctr[k] = ex_tk ? ((m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1)
                                          : ((m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1);
                    if (ex_jp || ex_tk) m_tgt[k] = ex_tgt;
                end else if (ex_tk) begin
                    m_valid[k] = 1; m_tag[k] = ex_pc >> 8; m_tgt[k] = ex_tgt;
                    m_ctr[k] = ex_jp ? 3 : 2;
                end
            end
            if (ex_v && !ex_br && !ex_jp && ex_ptk && h) m_valid[k] = 0;
            if (e_mis) m_mc++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor_2bit.md
Name: branch_predictor_2bit

Overview:
- Dynamic branch predictor plus branch target buffer (BTB) for the 5-stage RV32I pipeline; replaces the static not-taken policy.
- IF side: combinational lookup on the fetch PC gives a predicted direction and target for next-PC selection.
- EX side: accepts the resolved outcome, trains the table, and raises mispredict/redirect. The hazard unit turns mispredict into flushD/flushE.

Parameters:
INDEX_W, 6, log2 of table entries (64 entries); index = PC[INDEX_W+1:2]
XLEN, 32, PC/target width

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset  input  1  asynchronous, active-high reset
i_pc_if  input  XLEN  fetch PC (IF stage)
o_pred_taken  output  1  IF prediction: redirect fetch to o_pred_target
o_pred_target  output  XLEN  predicted next PC (BTB target if taken, else i_pc_if+4)
i_ex_valid  input  1  EX holds a real instruction (0 for bubble/flushed)
i_ex_pc  input  XLEN  PC of EX instruction
i_ex_is_branch  input  1  EX opcode is B-type (1100011)
i_ex_is_jump  input  1  EX opcode is JAL (1101111) or JALR (1100111)
i_ex_taken  input  1  resolved direction (pc_sel from EX)
i_ex_target  input  XLEN  resolved target address
i_ex_pred_taken  input  1  prediction carried down the pipe with this instruction
i_ex_pred_target  input  XLEN  predicted target carried down the pipe
o_mispredict  output  1  EX prediction wrong; flush IF/ID/EX younger instructions
o_redirect_pc  output  XLEN  correct next PC when o_mispredict=1
o_ctrl_cnt  output  32  count of trained control instructions
o_mispred_cnt  output  32  count of mispredicts

Behaviour:
- Entry fields: valid, tag = PC[XLEN-1:INDEX_W+2], target[XLEN-1:0], ctr[1:0] (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup (combinational, same cycle):
  - hit = valid[idx] && tag match.
  - o_pred_taken = hit && ctr[1].
  - o_pred_target = o_pred_taken ? target : i_pc_if+4 (wraps mod 2^XLEN).
- Mispredict (combinational):
  - Asserted when i_ex_valid && ((i_ex_taken != i_ex_pred_taken) || (i_ex_taken && i_ex_target != i_ex_pred_target)).
  - o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc+4.
  - When i_ex_valid=0: o_mispredict=0 and o_redirect_pc = i_ex_pc+4.
- Training (rising edge, i_ex_valid && (is_branch || is_jump)):
  - Hit, branch: ctr saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00). Target written when taken.
  - Hit, jump: ctr <= 11; target <= i_ex_target (handles JALR target changes).
  - Miss, taken: allocate (overwrite) with valid=1, new tag, target=i_ex_target, ctr = 10 for branch or 11 for jump.
  - Miss, not taken: no table write.
- Stale entry: i_ex_valid && !is_branch && !is_jump && i_ex_pred_taken (entry left over from earlier code).
  - o_mispredict=1 and redirect to i_ex_pc+4, since i_ex_taken must be 0 for non-control.
  - Entry at the EX index is invalidated if its tag matches.
- Same-cycle lookup and train on the same index: lookup returns the pre-edge contents (no write-through bypass).
- Statistics:
  - o_ctrl_cnt +1 per training event.
  - o_mispred_cnt +1 per cycle with o_mispredict=1.
  - Both wrap at 2^32 to 0.
- Reset (async, any time, including mid-training):
  - Immediately clears all valid bits, ctr to 00, and both counters to 0.
  - o_pred_taken=0 and o_pred_target=i_pc_if+4 from the moment reset asserts.
  - No training occurs while reset is high.
- Latency: prediction 0 cycles; training visible to lookups from the cycle after the training edge.

Test Plan:
- Reset then lookup PC=0x100 -> o_pred_taken=0, o_pred_target=0x104; both counters 0.
- EX branch PC=0x100 taken to 0x80, pred_taken=0 -> o_mispredict=1, o_redirect_pc=0x80. Next cycle, lookup 0x100 -> pred_taken=1, target=0x80, ctr=10.
- Train 0x100 as taken 3 times, then not taken once -> ctr 11 then 10, prediction still taken. Second not-taken -> ctr 01, o_pred_taken=0, o_pred_target=0x104.
- JALR at 0x200, target 0x300 then 0x340 with pred_target=0x300 -> o_mispredict=1 with redirect 0x340. Next lookup target=0x340, o_mispred_cnt incremented.
- Alias: 0x100 and 0x100+(64<<2)=0x200 share an index.
  - Train 0x200 taken -> lookup 0x100 misses (tag mismatch).
  - Stale case: non-control EX at 0x200 with pred_taken=1 -> mispredict, redirect 0x204, entry invalidated.
- Assert i_reset mid-cycle while a trained entry predicts taken -> o_pred_taken drops to 0 immediately; after deassert, lookup misses and counters read 0.
